// File: rtl/dmem_arbiter_if.sv
// Request/response bus between one data-memory master and the arbiter.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [2:0]        memop;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, addr, wdata, memop, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, memop, output gnt, rvalid, rdata);
endinterface

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the core (default priority) and a
// secondary master that is guaranteed a grant after MAX_WAIT denied cycles.
module dmem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    dmem_arbiter_if.slave     c,
    dmem_arbiter_if.slave     d,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_memop,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata
);
    typedef enum logic {P_CORE, P_SEC} prio_e;

    localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

    prio_e             state_q, state_d;
    logic [3:0]        wait_q, wait_d, wait_inc;
    logic              c_rvalid_q, c_rvalid_d, d_rvalid_q, d_rvalid_d;
    logic [DATA_W-1:0] c_rdata_q, c_rdata_d, d_rdata_q, d_rdata_d;
    logic              c_gnt, d_gnt;

    assign wait_inc = wait_q + 4'd1;

    always_comb begin
        c_gnt = 1'b0;
        d_gnt = 1'b0;
        // Grants are forced low while reset is held so memory sees no access.
        if (!reset) begin
            case (state_q)
                P_CORE: begin
                    if (c.req)      c_gnt = 1'b1;
                    else if (d.req) d_gnt = 1'b1;
                end
                default: begin
                    if (d.req)      d_gnt = 1'b1;
                    else if (c.req) c_gnt = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        wait_d  = wait_q;
        state_d = state_q;
        if (d_gnt || !d.req)       wait_d = 4'd0;
        else if (wait_q < WAIT_LIM) wait_d = wait_inc;

        case (state_q)
            P_CORE: if (d.req && !d_gnt && wait_inc == WAIT_LIM) state_d = P_SEC;
            default: if (d_gnt || !d.req) state_d = P_CORE;
        endcase
    end

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_memop = 3'b000;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        if (c_gnt) begin
            mem_addr  = c.addr;
            mem_wdata = c.wdata;
            mem_memop = c.memop;
            mem_we    = c.we;
            mem_re    = !c.we;
        end else if (d_gnt) begin
            mem_addr  = d.addr;
            mem_wdata = d.wdata;
            mem_memop = d.memop;
            mem_we    = d.we;
            mem_re    = !d.we;
        end
    end

    // Read data is captured at the grant edge; rdata holds until the next read.
    always_comb begin
        c_rvalid_d = c_gnt && !c.we;
        d_rvalid_d = d_gnt && !d.we;
        c_rdata_d  = c_rvalid_d ? mem_rdata : c_rdata_q;
        d_rdata_d  = d_rvalid_d ? mem_rdata : d_rdata_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= P_CORE;
            wait_q     <= 4'd0;
            c_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            c_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            c_rvalid_q <= c_rvalid_d;
            d_rvalid_q <= d_rvalid_d;
            c_rdata_q  <= c_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign c.gnt    = c_gnt;
    assign d.gnt    = d_gnt;
    assign c.rvalid = c_rvalid_q;
    assign d.rvalid = d_rvalid_q;
    assign c.rdata  = c_rdata_q;
    assign d.rdata  = d_rdata_q;
endmodule
